fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
- Read-side controller for the FIFO built around the simple-dual-port distributed RAM.
- Drives the RAM read address, consumes the combinational RAM read data, and presents a first-word-fall-through valid/ready stream downstream.
- Exports its read pointer so the write side can compute "full".
- Same clock domain as the write side; no CDC.

Parameters:
- DATA_WIDTH, 32, word width; must equal the RAM DATA_WIDTH.
- MEM_DEPTH, 16, RAM depth; must be a power of 2. Violation gives $error + $fatal at elaboration (use is_pow2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous discard of all unread data.
- wr_ptr  in  AW+1  write pointer from the write side; binary, MSB is the wrap bit (AW = $clog2(MEM_DEPTH)).
- rd_ptr  out  AW+1  read pointer to the write side; same format as wr_ptr.
- rd_addr  out  AW  RAM read address; equals rd_ptr[AW-1:0].
- rd_data  in  DATA_WIDTH  combinational RAM read data at rd_addr.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output word (registered).
- ptr_err  out  1  sticky pointer-protocol error.

Behaviour:
- Reset (rst_n low at a rising edge): rd_ptr=0, m_valid=0, m_data=0, ptr_err=0. The RAM contents are not this block's concern.
- Derived signals:
  - avail = wr_ptr - rd_ptr, modulo 2^(AW+1).
  - ram_empty = (avail==0).
- Two-state FSM:
  - IDLE: m_valid=0.
  - HOLD: m_valid=1.
- Fetch condition: fetch = !ram_empty && (IDLE || m_ready).
- On fetch:
  - m_data <= rd_data.
  - rd_ptr <= rd_ptr+1 (wraps naturally at 2^(AW+1)).
  - Next state HOLD.
- HOLD && m_ready && !fetch: next state IDLE. m_data keeps its value (no clearing).
- HOLD && !m_ready: m_data and m_valid are stable; no fetch. The AXI-style rule applies: m_data must not change while m_valid && !m_ready.
- Latency: wr_ptr advances at edge E → m_valid=1 after edge E+1 (provided IDLE).
- Throughput: 1 word/cycle sustained when m_ready=1 and data is available.
- Capacity: the output register is an extra slot. The writer's full check is (wr_ptr - rd_ptr)==MEM_DEPTH, so total storage is MEM_DEPTH+1.
- Wrap-around: rd_addr wraps from MEM_DEPTH-1 to 0 and the MSB of rd_ptr toggles. Pointer equality including the MSB means empty.
- flush (priority below reset, above everything else):
  - rd_ptr <= wr_ptr (current value); m_valid <= 0; state IDLE; no fetch that cycle.
  - A word handshaked (m_valid && m_ready) in the flush cycle counts as delivered.
- ptr_err: set when avail > MEM_DEPTH (the writer overran). Sticky until reset; flush does not clear it. While ptr_err=1, normal operation continues.
- Simultaneous m_ready and fetch in HOLD: the old word is accepted and the new word loads in the same edge; m_valid stays 1.

Optional Feature:
- Macro: FIFO_RD_LEVEL_EN.
- Defined: adds output port rd_level, width AW+1.
  - rd_level = avail + m_valid, combinational from registers.
  - Range 0..MEM_DEPTH+1; saturates at MEM_DEPTH+1 if ptr_err.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- generic_func_pack: reuse is_pow2.
- New fifo_pack:
  - Function ptr_w(depth) returning $clog2(depth)+1.
  - typedef enum logic {RD_IDLE, RD_HOLD} rd_state_t.
- One natural sub-module: fifo_ptr, a wrap-bit binary pointer with inc and load inputs and synchronous active-low reset. It is shared later by the write-side controller.

Test Plan:
All scenarios use DATA_WIDTH=8, MEM_DEPTH=4, with a RAM model attached.
- Reset: rst_n=0 for 2 cycles with wr_ptr=3 → rd_ptr=0, m_valid=0, m_data=0, ptr_err=0; after release, m_valid=1 one edge later with m_data=mem[0].
- Streaming: write 0x11,0x22,0x33,0x44, then wr_ptr=4, m_ready=1 → m_data 0x11..0x44 on 4 consecutive valid cycles; rd_ptr=4; then m_valid=0.
- Backpressure: m_ready=0 with wr_ptr=4 → m_valid=1, m_data=0x11 held for 10 cycles, rd_ptr=1. The writer then sees avail=3 and can fill 1 more.
- Wrap: run 9 words through with m_ready toggling each cycle → in-order data, rd_addr sequence 0,1,2,3,0,..., rd_ptr MSB toggles at word 4 and rd_ptr=1 after 9 words.
- Flush: 3 words pending, m_valid=1, assert flush with m_ready=0 → next cycle m_valid=0, rd_ptr=wr_ptr=3, no words emitted.
- Error: force wr_ptr=5 while rd_ptr=0 → ptr_err=1 after the edge; it stays 1 through flush and clears only on rst_n=0. With FIFO_RD_LEVEL_EN, rd_level=5 is reported (saturated).

Source files
------------

// File: rtl/fifo_pack.sv
// ---------------------------------------------------------------------------
// fifo_pack
// Shared definitions for the FIFO read/write controllers.
//   ptr_w(depth) : width of a wrap-bit binary pointer for a RAM of 'depth'
//                  words ($clog2(depth) address bits plus one wrap bit).
//   rd_state_t   : read-side output-slot state (empty / holding a word).
// ---------------------------------------------------------------------------
package fifo_pack;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_HOLD = 1'b1
  } rd_state_t;

endpackage

// File: rtl/generic_func_pack.sv
// ---------------------------------------------------------------------------
// generic_func_pack
// Small, design-independent helper functions shared across the codebase.
//   is_pow2(n) : 1 when n is a non-zero power of two.
// ---------------------------------------------------------------------------
package generic_func_pack;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// ---------------------------------------------------------------------------
// fifo_ptr
// Wrap-bit binary pointer. The MSB is the wrap bit, the remaining bits are
// the RAM address. Increments roll over naturally at 2^PTR_W.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset (pointer -> 0)
//   inc      in   advance pointer by one
//   load     in   load load_val (wins over inc)
//   load_val in   value to load
//   ptr      out  current pointer value
// ---------------------------------------------------------------------------
module fifo_ptr #(
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load,
  input  logic [PTR_W-1:0] load_val,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of the distributed-RAM FIFO. Addresses the RAM,
// captures its combinational read data into a registered output slot and
// presents it as a first-word-fall-through valid/ready stream. The output
// slot is one extra word of storage on top of the RAM.
// Optional feature macro: FIFO_RD_LEVEL_EN (adds the rd_level output).
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   flush    in   discard all unread data (RAM words and output slot)
//   wr_ptr   in   write pointer (binary, MSB = wrap bit)
//   rd_ptr   out  read pointer back to the write side
//   rd_addr  out  RAM read address (rd_ptr without wrap bit)
//   rd_data  in   combinational RAM read data at rd_addr
//   m_valid  out  output word valid
//   m_ready  in   downstream accept
//   m_data   out  output word (registered)
//   ptr_err  out  sticky: writer overran the reader
//   rd_level out  (FIFO_RD_LEVEL_EN only) words held incl. output slot
// ---------------------------------------------------------------------------
module fifo_rd_ctrl
  import generic_func_pack::*;
  import fifo_pack::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [ptr_w(MEM_DEPTH)-1:0]   wr_ptr,
  output logic [ptr_w(MEM_DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(MEM_DEPTH)-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          ptr_err
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ptr_w(MEM_DEPTH)-1:0]   rd_level
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = ptr_w(MEM_DEPTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(MEM_DEPTH);

  if (!is_pow2(MEM_DEPTH)) begin : g_depth_chk
    $error("fifo_rd_ctrl: MEM_DEPTH=%0d is not a power of two", MEM_DEPTH);
    $fatal(1, "fifo_rd_ctrl: invalid MEM_DEPTH");
  end

  rd_state_t       state;
  rd_state_t       state_nxt;
  logic [PW-1:0]   avail;
  logic            ram_empty;
  logic            fetch;

  // Modulo arithmetic on the wrap-bit pointers gives the RAM occupancy
  // directly; equality including the MSB means empty.
  assign avail     = wr_ptr - rd_ptr;
  assign ram_empty = (avail == '0);

  // A word is pulled from the RAM whenever the slot is empty or is being
  // drained this cycle; flush suppresses it.
  assign fetch = !flush && !ram_empty && ((state == RD_IDLE) || m_ready);

  fifo_ptr #(
    .PTR_W (PW)
  ) u_rd_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (fetch),
    .load     (flush),
    .load_val (wr_ptr),
    .ptr      (rd_ptr)
  );

  assign rd_addr = rd_ptr[AW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RD_IDLE;
    end else if (fetch) begin
      state_nxt = RD_HOLD;
    end else if ((state == RD_HOLD) && m_ready) begin
      state_nxt = RD_IDLE;
    end
  end

  // Output logic
  always_comb begin
    m_valid = (state == RD_HOLD);
  end

  // RAM read -> output slot boundary. The slot only loads on fetch, so it is
  // stable while m_valid && !m_ready and keeps its old value after draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_data <= '0;
    end else if (fetch) begin
      m_data <= rd_data;
    end
  end

  // Overrun is sticky; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_err <= 1'b0;
    end else if (avail > DEPTH_P) begin
      ptr_err <= 1'b1;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  localparam logic [PW:0] LVL_MAX = (PW+1)'(MEM_DEPTH + 1);
  logic [PW:0] level_sum;

  // One bit wider than the port so an overrun sum cannot wrap before it is
  // clamped.
  assign level_sum = {1'b0, avail} + {{PW{1'b0}}, m_valid};
  assign rd_level  = (ptr_err || (level_sum > LVL_MAX)) ? LVL_MAX[PW-1:0]
                                                      : level_sum[PW-1:0];
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int MD = 4;
  localparam int AW = 2;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          ptr_err;
`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] rd_level;
`endif

  logic [DW-1:0] mem [MD];
  assign rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (MD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .ptr_err  (ptr_err)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level (rd_level)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the reader owns an output slot plus a read count into
  // the RAM. Each edge the slot refills from the RAM if it is empty or being
  // taken and the RAM holds a word; a taken slot with nothing behind it empties.
  logic [PW-1:0] m_rd  = '0;
  bit            m_vld = 1'b0;
  bit            m_err = 1'b0;
  logic [DW-1:0] m_dat = '0;

  always @(posedge clk) begin : model
    int occ;
    bit slot_free;
    occ = int'(PW'(wr_ptr - m_rd));
    if (!rst_n) begin
      m_rd = '0; m_vld = 1'b0; m_dat = '0; m_err = 1'b0;
    end else begin
      if (occ > MD) m_err = 1'b1;
      slot_free = !m_vld || m_ready;
      if (flush) begin
        m_rd  = wr_ptr;
        m_vld = 1'b0;
      end else if (slot_free && occ > 0) begin
        m_dat = mem[m_rd % MD];
        m_rd  = PW'(m_rd + 1);
        m_vld = 1'b1;
      end else if (slot_free) begin
        m_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (cmp_en) begin
      chk("rd_ptr",  rd_ptr,  m_rd);
      chk("rd_addr", rd_addr, m_rd % MD);
      chk("m_valid", m_valid, m_vld);
      chk("m_data",  m_data,  m_dat);
      chk("ptr_err", ptr_err, m_err);
`ifdef FIFO_RD_LEVEL_EN
      begin
        int lvl;
        lvl = int'(PW'(wr_ptr - m_rd)) + int'(m_vld);
        if (m_err || lvl > MD + 1) lvl = MD + 1;
        chk("rd_level", rd_level, lvl);
      end
`endif
    end
  end

  logic [DW-1:0] sbq[$];
  logic [DW-1:0] got[$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input bit track);
    mem[wr_ptr % MD] = d;
    wr_ptr = PW'(wr_ptr + 1);
    if (track) sbq.push_back(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; wr_ptr = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DW-1:0] exp4 [4];
    logic [PW-1:0] av;
    bit msb_seen;
    int sent;

    // Reset with data pending in the RAM
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; wr_ptr = 3'd3;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_ptr_err", ptr_err, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_rel_valid", m_valid, 1);
    chk("rst_rel_data", m_data, 8'hA0);

    // Streaming four words back to back
    do_reset();
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    for (int i = 0; i < 4; i++) push(exp4[i], 1'b0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_valid", m_valid, 1);
      chk("stream_data", m_data, exp4[i]);
    end
    chk("stream_rd_ptr", rd_ptr, 4);
    tick();
    chk("stream_drained", m_valid, 0);

    // Backpressure holds the first word, then the extra slot takes a fifth
    do_reset();
    for (int i = 0; i < 4; i++) push(exp4[i], 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", m_valid, 1);
      chk("bp_data", m_data, 8'h11);
      tick();
    end
    chk("bp_rd_ptr", rd_ptr, 1);
    av = wr_ptr - rd_ptr;
    chk("bp_avail", av, 3);
    push(8'h55, 1'b0);
    m_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      if (m_valid && m_ready) got.push_back(m_data);
      tick();
    end
    chk("bp_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk("bp_order", got[i], (i < 4) ? exp4[i] : 8'h55);

    // Wrap-around with m_ready toggling
    do_reset();
    got.delete();
    sent = 0;
    msb_seen = 1'b0;
    for (int cyc = 0; cyc < 80 && got.size() < 9; cyc++) begin
      m_ready = cyc[0];
      if (sent < 9 && PW'(wr_ptr - rd_ptr) != PW'(MD)) begin
        push(DW'(8'h60 + sent), 1'b0);
        sent++;
      end
      if (m_valid && m_ready) got.push_back(m_data);
      tick();
      if (rd_ptr[PW-1]) msb_seen = 1'b1;
    end
    chk("wrap_count", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++)
      chk("wrap_order", got[i], 8'h60 + i);
    chk("wrap_rd_ptr", rd_ptr, 1);
    chk("wrap_msb_seen", msb_seen, 1);

    // Flush with words pending and the slot full
    do_reset();
    push(8'h71, 1'b0); push(8'h72, 1'b0); push(8'h73, 1'b0);
    tick();
    chk("flush_pre_valid", m_valid, 1);
    chk("flush_pre_rd_ptr", rd_ptr, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", m_valid, 0);
    chk("flush_rd_ptr", rd_ptr, 3);
    tick();
    chk("flush_after_valid", m_valid, 0);

    // Writer overrun
    do_reset();
    wr_ptr = 3'd5;
    tick();
    chk("err_set", ptr_err, 1);
`ifdef FIFO_RD_LEVEL_EN
    chk("err_level", rd_level, 5);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("err_after_flush", ptr_err, 1);
    chk("err_flush_rd_ptr", rd_ptr, 5);
    tick();
    chk("err_sticky", ptr_err, 1);
    rst_n = 1'b0; wr_ptr = '0;
    tick();
    chk("err_cleared", ptr_err, 0);
    rst_n = 1'b1;

    // Randomized traffic with an in-order scoreboard
    do_reset();
    sbq.delete();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      m_ready = ($urandom_range(0, 9) < 7);
      if (r < 1) begin
        rst_n = 1'b0; flush = 1'b0; wr_ptr = '0;
        sbq.delete();
      end else begin
        rst_n = 1'b1;
        if (m_valid && m_ready) begin
          if (sbq.size() == 0) chk("sb_underflow", 1, 0);
          else chk("sb_data", m_data, sbq.pop_front());
        end
        if (r < 4) begin
          flush = 1'b1;
          sbq.delete();
        end else begin
          flush = 1'b0;
          if ($urandom_range(0, 9) < 6 && PW'(wr_ptr - rd_ptr) != PW'(MD))
            push(DW'($urandom), 1'b1);
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
